// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
// -------------
// Drives the select/enable pins of a 3-to-8 decoder so that the board LEDs
// show a moving one-hot pattern. An internal prescaler holds each address for
// exactly CLK_DIV clock cycles. Four scan modes are available: up-wrap,
// down-wrap, ping-pong and a single upward sweep that ends with a done pulse.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   level; begins a scan when idle (ignored while running)
//   stop   in   level; aborts a running scan, wins over stepping/completion
//   mode   in   00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single sweep up
//   addr   out  decoder select (3-bit)
//   en     out  decoder enable, high while scanning
//   busy   out  high while scanning
//   done   out  one-cycle pulse when a single sweep completes

module led_scan_ctrl #(
    parameter int CLK_DIV = 50_000_000,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    output logic [2:0] addr,
    output logic       en,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_PING   = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(CLK_DIV - 1);

    state_t             state_q, state_d;
    logic [2:0]         addr_q, addr_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;

    // State and datapath registers; reset acts immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 3'd0;
            done_q  <= 1'b0;
            presc_q <= '0;
            dir_q   <= DIR_UP;
            mode_q  <= MODE_UP;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic. done defaults low so it can only ever pulse for a
    // single cycle. The mode is latched at start so that changes on the
    // switches during a scan have no effect.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        presc_d = presc_q;
        dir_d   = dir_q;
        mode_d  = mode_q;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mode_d  = mode;
                    addr_d  = (mode == MODE_DOWN) ? 3'd7 : 3'd0;
                    dir_d   = (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
                    presc_d = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (stop) begin
                    // Abort: address freezes where it is, no done pulse.
                    state_d = IDLE;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    unique case (mode_q)
                        MODE_UP:   addr_d = addr_q + 3'd1;
                        MODE_DOWN: addr_d = addr_q - 3'd1;
                        MODE_PING: begin
                            // Direction flips on the step that lands on an
                            // endpoint, so each endpoint is shown only once.
                            if (dir_q == DIR_UP) begin
                                addr_d = addr_q + 3'd1;
                                if (addr_q == 3'd6) dir_d = DIR_DOWN;
                            end else begin
                                addr_d = addr_q - 3'd1;
                                if (addr_q == 3'd1) dir_d = DIR_UP;
                            end
                        end
                        MODE_SINGLE: begin
                            if (addr_q == 3'd7) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                addr_d = addr_q + 3'd1;
                            end
                        end
                        default: addr_d = addr_q;
                    endcase
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from flops: en/busy are the state bit itself.
    always_comb begin
        addr = addr_q;
        en   = (state_q == RUN);
        busy = (state_q == RUN);
        done = done_q;
    end

endmodule
